// File: rtl/spike_rate_decoder.sv
// Spike-rate decoder: counts spike_in over a programmable window and hands each
// window's saturated count to the consumer through a valid/ready output register.
module spike_rate_decoder #(
    parameter int WIDTH     = 8,
    parameter int WIN_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 spike_in,
    input  logic                 enable,
    input  logic [WIN_WIDTH-1:0] window_len,
    output logic [WIDTH-1:0]     rate_out,
    output logic                 rate_valid,
    input  logic                 rate_ready,
    output logic                 overrun,
    output logic                 busy
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_COUNT = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [WIN_WIDTH-1:0]   r_win_cnt;
    logic [WIN_WIDTH-1:0]   r_len_q;
    logic [WIDTH-1:0]       r_spk_cnt;
    logic [WIDTH-1:0]       r_rate;
    logic                   r_rate_vld;
    logic                   r_overrun;

    logic [WIN_WIDTH-1:0]   w_len_start;
    logic [WIDTH-1:0]       w_spk_next;
    logic                   w_last;
    logic                   w_result;

    function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] a, input logic inc);
        if (inc && (a != {WIDTH{1'b1}}))
            return a + WIDTH'(1);
        return a;
    endfunction

    // A zero window length would never terminate, so it is promoted to one cycle.
    assign w_len_start = (window_len == '0) ? WIN_WIDTH'(1) : window_len;
    assign w_spk_next  = sat_inc(r_spk_cnt, spike_in);
    assign w_last      = (r_win_cnt == (r_len_q - WIN_WIDTH'(1)));
    assign w_result    = (r_state == S_COUNT) && enable && w_last;

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  w_state_nxt = enable ? S_COUNT : S_IDLE;
            S_COUNT: w_state_nxt = enable ? S_COUNT : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == S_COUNT);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_win_cnt <= '0;
            r_spk_cnt <= '0;
            r_len_q   <= '0;
        end else if (r_state == S_IDLE) begin
            if (enable) begin
                r_win_cnt <= '0;
                r_spk_cnt <= '0;
                r_len_q   <= w_len_start;
            end
        end else if (!enable) begin
            // Abort discards the partial window.
            r_win_cnt <= '0;
            r_spk_cnt <= '0;
        end else if (w_last) begin
            r_win_cnt <= '0;
            r_spk_cnt <= '0;
            r_len_q   <= w_len_start;
        end else begin
            r_win_cnt <= r_win_cnt + WIN_WIDTH'(1);
            r_spk_cnt <= w_spk_next;
        end
    end

    // Output register: a new result may load on the same edge the old one is taken.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rate     <= '0;
            r_rate_vld <= 1'b0;
            r_overrun  <= 1'b0;
        end else if (w_result) begin
            if (!r_rate_vld || rate_ready) begin
                r_rate     <= w_spk_next;
                r_rate_vld <= 1'b1;
            end else begin
                r_overrun  <= 1'b1;
            end
        end else if (r_rate_vld && rate_ready) begin
            r_rate_vld <= 1'b0;
        end
    end

    assign rate_out   = r_rate;
    assign rate_valid = r_rate_vld;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Directed bench for spike_rate_decoder: expected rates queue up as stimulus is
// issued and a negedge monitor checks each one as the consumer takes it.
module tb_spike_rate_decoder;

    localparam int WIDTH     = 4;
    localparam int WIN_WIDTH = 8;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 spike_in;
    logic                 enable;
    logic [WIN_WIDTH-1:0] window_len;
    logic [WIDTH-1:0]     rate_out;
    logic                 rate_valid;
    logic                 rate_ready;
    logic                 overrun;
    logic                 busy;

    int n_chk  = 0;
    int n_fail = 0;
    int exp_q[$];

    spike_rate_decoder #(.WIDTH(WIDTH), .WIN_WIDTH(WIN_WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .spike_in   (spike_in),
        .enable     (enable),
        .window_len (window_len),
        .rate_out   (rate_out),
        .rate_valid (rate_valid),
        .rate_ready (rate_ready),
        .overrun    (overrun),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // A transfer happens at the next posedge whenever valid and ready are both high here.
    always @(negedge clk) begin
        if (rst_n && rate_valid && rate_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", int'(rate_out), -1);
            end else begin
                chk("scoreboard_rate", int'(rate_out), exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int pat_min[5] = '{1, 0, 1, 1, 0};
        int pat_rst[8] = '{0, 1, 0, 0, 1, 0, 0, 0};

        rst_n = 1'b0; enable = 1'b0; spike_in = 1'b0; window_len = '0; rate_ready = 1'b0;
        tick(); tick();
        chk("reset_rate_out", int'(rate_out), 0);
        chk("reset_valid", int'(rate_valid), 0);
        chk("reset_overrun", int'(overrun), 0);
        chk("reset_busy", int'(busy), 0);
        rst_n = 1'b1;

        // Basic count: 1,0,1,1 over a 4-cycle window
        window_len = 8'd4; rate_ready = 1'b1; enable = 1'b1;
        tick();
        chk("basic_busy", int'(busy), 1);
        exp_q.push_back(3);
        spike_in = 1'b1; tick();
        spike_in = 1'b0; tick();
        spike_in = 1'b1; tick();
        spike_in = 1'b1; tick();
        chk("basic_valid", int'(rate_valid), 1);
        chk("basic_rate", int'(rate_out), 3);
        enable = 1'b0; spike_in = 1'b0;
        tick();
        chk("basic_valid_drop", int'(rate_valid), 0);
        chk("basic_busy_drop", int'(busy), 0);

        // Saturation: 20 spikes into a 4-bit counter
        window_len = 8'd20; spike_in = 1'b1; enable = 1'b1;
        tick();
        exp_q.push_back(15);
        exp_q.push_back(15);
        for (int i = 0; i < 20; i++) tick();
        chk("sat_rate_w1", int'(rate_out), 15);
        for (int i = 0; i < 20; i++) tick();
        chk("sat_rate_w2", int'(rate_out), 15);
        enable = 1'b0; spike_in = 1'b0;
        tick();

        // Zero window length behaves as one-cycle windows
        window_len = 8'd0; enable = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            spike_in = pat_min[i][0];
            exp_q.push_back(pat_min[i]);
            tick();
            chk("minwin_rate", int'(rate_out), pat_min[i]);
        end
        enable = 1'b0; spike_in = 1'b0;
        tick();

        // Backpressure: second window dropped
        window_len = 8'd3; rate_ready = 1'b0; enable = 1'b1;
        tick();
        exp_q.push_back(3);
        spike_in = 1'b1; tick(); tick(); tick();
        spike_in = 1'b0; tick();
        spike_in = 1'b1; tick();
        spike_in = 1'b0; tick();
        chk("bp_rate_held", int'(rate_out), 3);
        chk("bp_valid", int'(rate_valid), 1);
        chk("bp_overrun", int'(overrun), 1);
        rate_ready = 1'b1; enable = 1'b0;
        tick();
        chk("bp_valid_drop", int'(rate_valid), 0);
        chk("bp_overrun_sticky", int'(overrun), 1);

        rst_n = 1'b0; rate_ready = 1'b0;
        tick();
        rst_n = 1'b1;

        // Consume and load on the same edge
        window_len = 8'd2; enable = 1'b1;
        tick();
        exp_q.push_back(2);
        exp_q.push_back(1);
        spike_in = 1'b1; tick(); tick();
        chk("simul_first", int'(rate_out), 2);
        spike_in = 1'b1; tick();
        spike_in = 1'b0; rate_ready = 1'b1;
        tick();
        chk("simul_valid", int'(rate_valid), 1);
        chk("simul_rate", int'(rate_out), 1);
        chk("simul_overrun", int'(overrun), 0);
        enable = 1'b0;
        tick();

        // Abort after 5 samples, then a clean window with a mid-window length change
        window_len = 8'd8; enable = 1'b1;
        tick();
        spike_in = 1'b1; tick(); tick();
        spike_in = 1'b0; tick();
        spike_in = 1'b1; tick();
        spike_in = 1'b0; tick();
        enable = 1'b0;
        tick();
        chk("abort_busy", int'(busy), 0);
        chk("abort_valid", int'(rate_valid), 0);
        enable = 1'b1;
        tick();
        exp_q.push_back(2);
        for (int i = 0; i < 8; i++) begin
            spike_in = pat_rst[i][0];
            tick();
            if (i == 0) window_len = 8'd3;
        end
        chk("restart_valid", int'(rate_valid), 1);
        chk("restart_rate", int'(rate_out), 2);
        enable = 1'b0; spike_in = 1'b0;
        tick();

        // Reset with a pending result, overrun set and a window in flight
        window_len = 8'd2; rate_ready = 1'b0; spike_in = 1'b1; enable = 1'b1;
        tick();
        tick(); tick(); tick(); tick(); tick();
        chk("prerst_overrun", int'(overrun), 1);
        chk("prerst_valid", int'(rate_valid), 1);
        chk("prerst_busy", int'(busy), 1);
        rst_n = 1'b0;
        tick();
        chk("midrst_rate", int'(rate_out), 0);
        chk("midrst_valid", int'(rate_valid), 0);
        chk("midrst_overrun", int'(overrun), 0);
        chk("midrst_busy", int'(busy), 0);
        rst_n = 1'b1; rate_ready = 1'b1;
        tick();
        chk("postrst_busy", int'(busy), 1);
        chk("postrst_valid", int'(rate_valid), 0);
        exp_q.push_back(2);
        tick(); tick();
        chk("postrst_rate", int'(rate_out), 2);
        enable = 1'b0; spike_in = 1'b0;
        tick(); tick();

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
